arb_mux: RTL and testbench

- Parametrised, registered N-channel multiplexer with valid/ready handshakes and per-cycle arbitration.
- Replaces the plain 2:1 combinational mux wherever several producers share one 16-bit bus.
- Typical uses: memory/IO write-back path, instruction-fetch vs. data-port sharing.
- Output is a single-entry register stage, so one-cycle latency and full throughput.

---
 rtl/arb_defs_pkg.sv | 12 +
 rtl/arb_mux_prio_enc.sv | 35 +++
 rtl/arb_mux.sv | 99 +++++++++
 tb/tb_arb_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_defs_pkg.sv
// Shared arbitration definitions: policy codes and the grant-index width helper.
package arb_defs_pkg;

  localparam int ARB_FIXED = 0;  // fixed priority, channel 0 highest
  localparam int ARB_RR    = 1;  // round-robin starting at the rotating pointer

  // Width of a channel index; a single channel pair still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_prio_enc.sv
// Rotating priority encoder: first set request at or after 'start', wrapping at N.
module prio_enc
  import arb_defs_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Walk the channels from 'start' and keep the first requester found.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      // NOTE: blocking assignments here are intentional: later iterations must
      // see grant_valid already set by an earlier hit in the same evaluation.
      idx = int'(start) + k;
      // Explicit wrap so non-power-of-two channel counts stay in range.
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-channel valid/ready multiplexer with fixed-priority or
// round-robin arbitration; one-cycle latency, one word per cycle.
module arb_mux
  import arb_defs_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 4,
  parameter  int MODE  = ARB_RR,
  localparam int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [SELW-1:0]  start;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load;

  // Fixed priority always searches from channel 0; round-robin from the pointer.
  generate
    if (MODE == ARB_RR) begin : g_rr_start
      assign start = rr_ptr_q;
    end else begin : g_fixed_start
      assign start = '0;
    end
  endgenerate

  prio_enc #(.N(N)) u_prio_enc (
    .req         (in_valid),
    .start       (start),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // The register can take a word when it is empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  // Accept only the granted channel; nothing is accepted while in reset since
  // the word would be discarded anyway.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load && grant_valid && !reset && (grant == SELW'(i));
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
        out_sel_d   = grant;
        out_valid_d = 1'b1;
        if (MODE == ARB_RR) begin
          rr_ptr_d = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; synchronous reset wins over any load.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (round-robin N=4, fixed N=4,
// round-robin N=3), a vector table, hand-written corner sequences and a
// scoreboard of expected output words.
module tb_arb_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Bench-driven inputs, indexed by instance (0: RR N4, 1: fixed N4, 2: RR N3).
  logic [63:0] id [3];
  logic [3:0]  iv [3];
  logic        ordy [3];

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [15:0] od0, od1, od2;
  logic        ov0, ov1, ov2;
  logic [1:0]  os0, os1, os2;

  arb_mux #(.WIDTH(16), .N(4), .MODE(1)) u_rr4 (
    .clk(clk), .reset(reset), .in_data(id[0]), .in_valid(iv[0]), .in_ready(rdy0),
    .out_data(od0), .out_valid(ov0), .out_ready(ordy[0]), .out_sel(os0));

  arb_mux #(.WIDTH(16), .N(4), .MODE(0)) u_fix4 (
    .clk(clk), .reset(reset), .in_data(id[1]), .in_valid(iv[1]), .in_ready(rdy1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy[1]), .out_sel(os1));

  arb_mux #(.WIDTH(16), .N(3), .MODE(1)) u_rr3 (
    .clk(clk), .reset(reset), .in_data(id[2][47:0]), .in_valid(iv[2][2:0]), .in_ready(rdy2),
    .out_data(od2), .out_valid(ov2), .out_ready(ordy[2]), .out_sel(os2));

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int         dut;
    logic [3:0] iv;
    logic       r;
    logic [3:0] rdy;
    logic       ov;
  } vec_t;

  exp_t sbq [$];
  vec_t vecs [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  function automatic logic [3:0] get_rdy(input int d);
    case (d)
      0:       return rdy0;
      1:       return rdy1;
      default: return {1'b0, rdy2};
    endcase
  endfunction

  function automatic logic [15:0] get_od(input int d);
    case (d)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [1:0] get_os(input int d);
    case (d)
      0:       return os0;
      1:       return os1;
      default: return os2;
    endcase
  endfunction

  function automatic void add(input int d, input logic [3:0] v, input logic r,
                              input logic [3:0] rdy, input logic ov);
    vecs.push_back('{dut: d, iv: v, r: r, rdy: rdy, ov: ov});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle on instance d: drive inputs, check in_ready, score any word
  // leaving the register at this edge, record any word entering it, then
  // check out_valid after the edge.
  task automatic drive_step(input int d, input logic [3:0] v, input logic r,
                            input logic [3:0] exp_rdy, input logic exp_ov);
    exp_t e;
    step_no++;
    iv[d]   = v;
    ordy[d] = r;
    #1;
    check($sformatf("d%0d s%0d in_ready", d, step_no), 32'(get_rdy(d)), 32'(exp_rdy));
    if (get_ov(d) && r) begin
      if (sbq.size() == 0) begin
        check($sformatf("d%0d s%0d unexpected word", d, step_no), 32'(get_od(d)), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check($sformatf("d%0d s%0d out_data", d, step_no), 32'(get_od(d)), 32'(e.data));
        check($sformatf("d%0d s%0d out_sel", d, step_no), 32'(get_os(d)), 32'(e.sel));
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) sbq.push_back('{sel: 2'(i), data: id[d][i*16 +: 16]});
    end
    @(posedge clk);
    #1;
    check($sformatf("d%0d s%0d out_valid", d, step_no), 32'(get_ov(d)), 32'(exp_ov));
  endtask

  initial begin
    id[0] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    id[1] = {16'hA004, 16'hA003, 16'hA002, 16'hA001};
    id[2] = {16'h0000, 16'h0C22, 16'h0C11, 16'h0C00};
    iv[0] = 4'b1111; iv[1] = 4'b1111; iv[2] = 4'b0111;
    ordy[0] = 1'b1; ordy[1] = 1'b1; ordy[2] = 1'b1;
    reset = 1'b1;

    // Reset held two cycles with every channel requesting.
    repeat (2) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        check($sformatf("reset d%0d out_valid", d), 32'(get_ov(d)), 32'h0);
        check($sformatf("reset d%0d out_sel", d), 32'(get_os(d)), 32'h0);
        check($sformatf("reset d%0d out_data", d), 32'(get_od(d)), 32'h0);
        check($sformatf("reset d%0d in_ready", d), 32'(get_rdy(d)), 32'h0);
      end
    end
    reset = 1'b0;
    iv[0] = 4'b0000; iv[1] = 4'b0000; iv[2] = 4'b0000;

    // Fixed priority: ch1 beats ch3, ch3 only after ch1 drops, ch0 over all.
    add(1, 4'b1010, 1'b1, 4'b0010, 1'b1);
    add(1, 4'b1010, 1'b1, 4'b0010, 1'b1);
    add(1, 4'b1010, 1'b1, 4'b0010, 1'b1);
    add(1, 4'b1000, 1'b1, 4'b1000, 1'b1);
    add(1, 4'b0110, 1'b0, 4'b0000, 1'b1);
    add(1, 4'b1111, 1'b1, 4'b0001, 1'b1);
    add(1, 4'b0000, 1'b1, 4'b0000, 1'b0);
    // Round-robin N=3: sparse requests and pointer wrap 2 -> 0.
    add(2, 4'b0010, 1'b1, 4'b0010, 1'b1);
    add(2, 4'b0001, 1'b1, 4'b0001, 1'b1);
    add(2, 4'b0100, 1'b1, 4'b0100, 1'b1);
    add(2, 4'b0111, 1'b1, 4'b0001, 1'b1);
    add(2, 4'b0111, 1'b1, 4'b0010, 1'b1);
    add(2, 4'b0111, 1'b1, 4'b0100, 1'b1);
    add(2, 4'b0111, 1'b1, 4'b0001, 1'b1);
    add(2, 4'b0000, 1'b1, 4'b0000, 1'b0);
    // Round-robin N=4: first grant ch0, then fair rotation, one word per cycle.
    add(0, 4'b1111, 1'b1, 4'b0001, 1'b1);
    for (int k = 1; k < 9; k++) add(0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].dut, vecs[i].iv, vecs[i].r, vecs[i].rdy, vecs[i].ov);
    end

    // Backpressure: 0xBEEF on ch1 is loaded, then held through 5 stall cycles.
    id[0][31:16] = 16'hBEEF;
    drive_step(0, 4'b1111, 1'b1, 4'b0010, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive_step(0, 4'b1111, 1'b0, 4'b0000, 1'b1);
      check($sformatf("stall %0d out_data", k), 32'(od0), 32'h0000_BEEF);
      check($sformatf("stall %0d out_sel", k), 32'(os0), 32'h1);
    end
    // Release: ch2 next (pointer did not move while stalled), no bubble.
    drive_step(0, 4'b1111, 1'b1, 4'b0100, 1'b1);

    // Reset while a word (ch2) is stalled in the register: it must vanish.
    drive_step(0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    reset   = 1'b1;
    ordy[0] = 1'b0;
    #1;
    check("midreset in_ready", 32'(rdy0), 32'h0);
    @(posedge clk);
    #1;
    check("midreset out_valid", 32'(ov0), 32'h0);
    check("midreset out_data", 32'(od0), 32'h0);
    sbq.delete();
    reset = 1'b0;
    // Pointer back at 0: ch0 granted, and only that word is ever delivered.
    drive_step(0, 4'b1111, 1'b1, 4'b0001, 1'b1);
    drive_step(0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    check("scoreboard empty", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
